// File: rtl/score_bcd_counter.sv
// score_bcd_counter
//
// Keeps the running game score and the session high score as packed BCD
// digits. Each 4-bit nibble feeds one 7-segment decoder, so no nibble ever
// holds a value above 9.
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   reset      synchronous active-high clear of all state
//   clear      pulse, zero the running score (new game)
//   add_en     pulse, add add_val to the running score
//   add_val    points to add, binary 0..9 (10..15 is rejected)
//   game_over  pulse, commit the score to the high score if it is greater
//   show_high  level, selects the high score onto disp_bcd
//   score_bcd  running score, packed BCD, digit 0 in bits [3:0]
//   high_bcd   session high score, packed BCD
//   disp_bcd   show_high ? high_bcd : score_bcd
//   saturated  score is pinned at all-9s
//   new_high   one-cycle pulse, the last game_over raised the high score
//   bad_add    one-cycle pulse, add_en arrived with add_val above 9
module score_bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [3:0]            add_val,
    input  logic                  game_over,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  saturated,
    output logic                  new_high,
    output logic                  bad_add
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [W-1:0] score_q, score_d;
    logic [W-1:0] high_q, high_d;
    logic         saturated_q, saturated_d;
    logic         new_high_q, new_high_d;
    logic         bad_add_q, bad_add_d;

    logic [W-1:0] sum_bcd;
    logic         sum_carry;
    logic         add_valid;

    // Decimal adder: add_val enters on digit 0 and the carry ripples through
    // every digit in the same cycle. A carry out of the top digit means the
    // result no longer fits and the score must saturate instead of wrapping.
    // Worst case per digit is 9 + 9 + 1 = 19, so five bits are enough.
    always_comb begin
        logic [4:0] digit_sum;
        logic       carry;
        carry     = 1'b0;
        digit_sum = 5'd0;
        sum_bcd   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, score_q[4*i +: 4]} + {4'b0000, carry}
                      + ((i == 0) ? {1'b0, add_val} : 5'd0);
            if (digit_sum > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(digit_sum - 5'd10);
                carry             = 1'b1;
            end else begin
                sum_bcd[4*i +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        sum_carry = carry;
    end

    // Next-state for score, high score and the flags. Clear beats add, but an
    // out-of-range add_val is still reported even when clear swallows the add.
    // The high-score commit always looks at the registered score, so an add
    // or clear in the same cycle does not disturb it. Packed BCD of equal
    // width orders the same way as binary, so a plain compare is enough.
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = 1'b0;
        add_valid  = add_en && (add_val <= 4'd9);
        bad_add_d  = add_en && (add_val > 4'd9);

        if (clear) begin
            score_d = '0;
        end else if (add_valid && !saturated_q) begin
            score_d = sum_carry ? ALL_NINES : sum_bcd;
        end

        saturated_d = (score_d == ALL_NINES);

        if (game_over && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
    end

    // State registers; reset overrides every pending pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            score_q     <= '0;
            high_q      <= '0;
            saturated_q <= 1'b0;
            new_high_q  <= 1'b0;
            bad_add_q   <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            saturated_q <= saturated_d;
            new_high_q  <= new_high_d;
            bad_add_q   <= bad_add_d;
        end
    end

    // Display mux selects between two registered values, so it only changes
    // when show_high or a register changes.
    assign disp_bcd  = show_high ? high_q : score_q;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign saturated = saturated_q;
    assign new_high  = new_high_q;
    assign bad_add   = bad_add_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter
//
// Directed bench for score_bcd_counter with DIGITS = 4. Expected values are
// hand-computed decimal scores written as packed BCD constants.
module tb_score_bcd_counter;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        add_en;
    logic [3:0]  add_val;
    logic        game_over;
    logic        show_high;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [15:0] disp_bcd;
    logic        saturated;
    logic        new_high;
    logic        bad_add;

    int checks = 0;
    int errors = 0;

    score_bcd_counter #(.DIGITS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .add_en    (add_en),
        .add_val   (add_val),
        .game_over (game_over),
        .show_high (show_high),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .disp_bcd  (disp_bcd),
        .saturated (saturated),
        .new_high  (new_high),
        .bad_add   (bad_add)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hold the given pulse inputs across one rising edge, then drop them.
    // Outputs are stable 1 ns after the edge, which is where checks sample.
    task automatic applyStimulus(input logic rst, input logic clr, input logic add,
                                 input logic [3:0] val, input logic go);
        reset     = rst;
        clear     = clr;
        add_en    = add;
        add_val   = val;
        game_over = go;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        clear     = 1'b0;
        add_en    = 1'b0;
        add_val   = 4'd0;
        game_over = 1'b0;
    endtask

    task automatic addPoints(input logic [3:0] val);
        applyStimulus(1'b0, 1'b0, 1'b1, val, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Clear, then reach a target by nines plus a final remainder.
    task automatic buildScore(input int nines, input logic [3:0] rest);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < nines; i++) addPoints(4'd9);
        if (rest != 4'd0) addPoints(rest);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        add_en    = 1'b0;
        add_val   = 4'd0;
        game_over = 1'b0;
        show_high = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("rst_score", score_bcd, 16'h0000);
        checkOutput("rst_high", high_bcd, 16'h0000);
        checkOutput("rst_sat", {15'd0, saturated}, 16'd0);
        checkOutput("rst_newhigh", {15'd0, new_high}, 16'd0);
        checkOutput("rst_badadd", {15'd0, bad_add}, 16'd0);

        // Three back-to-back adds of 7: 7, 14, 21
        addPoints(4'd7);
        checkOutput("add7_once", score_bcd, 16'h0007);
        addPoints(4'd7);
        addPoints(4'd7);
        checkOutput("add7_x3", score_bcd, 16'h0021);
        checkOutput("add7_sat", {15'd0, saturated}, 16'd0);
        checkOutput("add7_disp", disp_bcd, 16'h0021);

        // 995 + 8 = 1003, carry through three digits
        buildScore(110, 4'd5);
        checkOutput("pre_995", score_bcd, 16'h0995);
        addPoints(4'd8);
        checkOutput("ripple_1003", score_bcd, 16'h1003);

        // 1003 + 8991 + 2 = 9996, then saturate
        for (int i = 0; i < 999; i++) addPoints(4'd9);
        addPoints(4'd2);
        checkOutput("pre_9996", score_bcd, 16'h9996);
        checkOutput("pre_9996_sat", {15'd0, saturated}, 16'd0);
        addPoints(4'd9);
        checkOutput("sat_score", score_bcd, 16'h9999);
        checkOutput("sat_flag", {15'd0, saturated}, 16'd1);
        addPoints(4'd1);
        checkOutput("sat_hold", score_bcd, 16'h9999);
        checkOutput("sat_hold_flag", {15'd0, saturated}, 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        checkOutput("clr_score", score_bcd, 16'h0000);
        checkOutput("clr_sat", {15'd0, saturated}, 16'd0);

        // Invalid add of 0xC at 12
        addPoints(4'd9);
        addPoints(4'd3);
        checkOutput("pre_12", score_bcd, 16'h0012);
        addPoints(4'hC);
        checkOutput("bad_score", score_bcd, 16'h0012);
        checkOutput("bad_flag", {15'd0, bad_add}, 16'd1);
        idleCycle();
        checkOutput("bad_drop", {15'd0, bad_add}, 16'd0);
        checkOutput("bad_score2", score_bcd, 16'h0012);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hC, 1'b0);
        checkOutput("bad_clr_score", score_bcd, 16'h0000);
        checkOutput("bad_clr_flag", {15'd0, bad_add}, 16'd1);

        // Clear beats a valid add in the same cycle
        addPoints(4'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        checkOutput("clr_wins", score_bcd, 16'h0000);

        // Game over with 150 against high 0
        buildScore(16, 4'd6);
        checkOutput("pre_150", score_bcd, 16'h0150);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("go_high", high_bcd, 16'h0150);
        checkOutput("go_pulse", {15'd0, new_high}, 16'd1);
        idleCycle();
        checkOutput("go_pulse_drop", {15'd0, new_high}, 16'd0);

        // Equal score does not update or pulse
        buildScore(16, 4'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("eq_high", high_bcd, 16'h0150);
        checkOutput("eq_pulse", {15'd0, new_high}, 16'd0);

        // 151 with game_over and clear together
        addPoints(4'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        checkOutput("goclr_high", high_bcd, 16'h0151);
        checkOutput("goclr_score", score_bcd, 16'h0000);
        checkOutput("goclr_pulse", {15'd0, new_high}, 16'd1);

        // Display select
        show_high = 1'b1;
        #1;
        checkOutput("disp_high", disp_bcd, 16'h0151);
        show_high = 1'b0;
        #1;
        checkOutput("disp_score", disp_bcd, 16'h0000);

        // Game over with add: commit uses pre-add score (lower, so no update)
        addPoints(4'd9);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        checkOutput("goadd_score", score_bcd, 16'h0014);
        checkOutput("goadd_high", high_bcd, 16'h0151);

        // Reset with add_en and game_over pending at 42
        buildScore(4, 4'd6);
        checkOutput("pre_42", score_bcd, 16'h0042);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hC, 1'b1);
        checkOutput("rst2_score", score_bcd, 16'h0000);
        checkOutput("rst2_high", high_bcd, 16'h0000);
        checkOutput("rst2_flags", {13'd0, saturated, new_high, bad_add}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Holds the game's running score and session high score as packed BCD digits.
- Drives the per-digit 7-segment decoders directly: each 4-bit nibble of disp_bcd goes to one hex display decoder.
- Sits between the game-control FSM, which issues score events, and the display stage.
- Never emits a nibble above 4'h9.

Parameters:
- DIGITS, 4: number of BCD digits in score and high score (1..6).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- clear  input  1  single-cycle pulse; zero the running score (new game).
- add_en  input  1  single-cycle pulse; add add_val to score.
- add_val  input  4  points to add, binary 0..9.
- game_over  input  1  single-cycle pulse; commit score to high score if greater.
- show_high  input  1  level; 1 selects high score onto disp_bcd.
- score_bcd  output  4*DIGITS  running score, packed BCD, digit 0 in bits [3:0].
- high_bcd  output  4*DIGITS  session high score, packed BCD.
- disp_bcd  output  4*DIGITS  show_high ? high_bcd : score_bcd (combinational mux of registered values).
- saturated  output  1  registered; 1 while score equals all-9s.
- new_high  output  1  registered one-cycle pulse; the game_over commit raised the high score.
- bad_add  output  1  registered one-cycle pulse; add_en seen with add_val > 9.

Behaviour:
- Reset (reset=1 at clock edge):
  - score, high = 0; saturated, new_high, bad_add = 0.
  - Reset overrides every other input in the same cycle.
- Add (add_en=1, add_val<=9, clear=0):
  - score_next = score + add_val in decimal, computed in one cycle with ripple BCD carry across digits.
  - Per digit: sum = digit + carry_in (+ add_val on digit 0); if sum>9, digit = sum-10 and carry_out = 1.
  - score_bcd reflects the new value the cycle after the pulse (latency 1).
- Saturation:
  - If the decimal sum would exceed 10^DIGITS-1, score = all-9s. No wrap.
  - saturated = 1 from the cycle the score reaches all-9s until clear or reset.
  - Adds while saturated leave score unchanged.
- Invalid add (add_en=1, add_val 10..15):
  - score unchanged.
  - bad_add = 1 for exactly the next cycle.
- Clear: score = 0 and saturated = 0 next cycle. high is unaffected.
- Clear and add_en in the same cycle: clear wins; add ignored; bad_add still flags an invalid add_val.
- Game over:
  - Compare the registered (pre-update) score with high as unsigned decimal; BCD compares correctly as binary.
  - If score > high: high = score and new_high = 1 next cycle.
  - Otherwise high is unchanged and new_high = 0.
  - Equal scores do not update and do not pulse.
- game_over combined with add_en or clear in the same cycle:
  - The high-score commit uses the pre-update score.
  - The add or clear still applies to score normally.
- Single-cycle flags: new_high and bad_add deassert the cycle after they assert unless retriggered.
- Back-to-back add_en pulses on consecutive cycles must each be applied; no lost events.
- disp_bcd follows show_high with zero latency, glitch-free relative to the registered sources.
- Reset mid-game: the next cycle shows score = high = 0 regardless of pending pulses.

Test Plan:
- Reset then add_en with add_val=7 three times -> score_bcd 16'h0021, saturated=0, disp_bcd=16'h0021 with show_high=0.
- Preload score 16'h0995 via adds; add_en, add_val=8 -> score_bcd 16'h1003, showing carry rippled across three digits in one cycle.
- Score at 16'h9996; add_en, add_val=9 -> score 16'h9999, saturated=1. A further add of 1 leaves 16'h9999. clear -> 16'h0000, saturated=0.
- add_en with add_val=4'hC at score 16'h0012 -> score unchanged, bad_add high exactly 1 cycle. Same cycle with clear=1 -> score 16'h0000, bad_add=1.
- Score 16'h0150, high 16'h0000, game_over -> high 16'h0150, new_high=1 pulse. New game to 16'h0150, game_over -> no update, new_high=0. Score 16'h0151 with game_over+clear same cycle -> high 16'h0151, score 16'h0000. show_high=1 -> disp_bcd=16'h0151.
- Score 16'h0042 with reset=1, add_en=1, game_over=1 in the same cycle -> score, high 0; all flags 0 next cycle.
